glyph_serializer: RTL

GLYPH_SERIALIZER -- requirements
Module: glyph_serializer

---
 rtl/glyph_pkg.sv | 23 ++
 rtl/glyph_serializer_if.sv | 28 ++
 rtl/glyph_pos_counter.sv | 44 ++++
 rtl/glyph_serializer.sv | 111 +++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph serializer.
//   GLYPH_COLS/ROWS/BITS : 5x7 font cell geometry, 35-bit row-major bitmap
//   state_e              : serializer control states
//   pix_index()          : linear bitmap offset of (row, col) counted from bit 34
package glyph_pkg;

  localparam int GLYPH_COLS = 5;
  localparam int GLYPH_ROWS = 7;
  localparam int GLYPH_BITS = GLYPH_COLS * GLYPH_ROWS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // Offset of pixel (row, col) from the MSB of the bitmap: row*5 + col.
  // Only meaningful for col < GLYPH_COLS; callers mask spacing columns.
  function automatic logic [5:0] pix_index(input logic [2:0] row, input logic [2:0] col);
    return 6'(row) * 6'(GLYPH_COLS) + 6'(col);
  endfunction

endpackage

// File: rtl/glyph_serializer_if.sv
// Character-in / pixel-out handshake bundle of the glyph serializer.
//   char_code/char_valid/char_ready : one character per valid&ready
//   pix_on/pix_valid/pix_ready      : one pixel per valid&ready
//   col_last/glyph_last             : framing flags qualified by pix_valid
// master: the side feeding characters and consuming pixels.
// slave : the serializer itself.
interface glyph_serializer_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] char_code;
  logic                  char_valid;
  logic                  char_ready;
  logic                  pix_on;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  col_last;
  logic                  glyph_last;

  modport master (
    output char_code, char_valid, pix_ready,
    input  char_ready, pix_on, pix_valid, col_last, glyph_last
  );

  modport slave (
    input  char_code, char_valid, pix_ready,
    output char_ready, pix_on, pix_valid, col_last, glyph_last
  );
endinterface

// File: rtl/glyph_pos_counter.sv
// Column-major position counter for one glyph plus its spacing columns.
//   clk, rst_n : clock, synchronous active-low reset
//   advance    : step to the next pixel (row first, then column)
//   clear      : force position back to col 0 / row 0
//   col, row   : current pixel position
//   col_last   : current pixel is the bottom row of its column
//   glyph_last : current pixel is the final one, spacing columns included
module glyph_pos_counter
  import glyph_pkg::*;
#(
  parameter int SPACING = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       clear,
  output logic [2:0] col,
  output logic [2:0] row,
  output logic       col_last,
  output logic       glyph_last
);

  localparam logic [2:0] LAST_COL = 3'(GLYPH_COLS - 1 + SPACING);
  localparam logic [2:0] LAST_ROW = 3'(GLYPH_ROWS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (row == LAST_ROW) begin
        row <= '0;
        // Wrapping at the end keeps the counter at 0/0 for a back-to-back glyph.
        col <= (col == LAST_COL) ? '0 : col + 3'd1;
      end else begin
        row <= row + 3'd1;
      end
    end
  end

  assign col_last   = (row == LAST_ROW);
  assign glyph_last = col_last && (col == LAST_COL);

endmodule

// File: rtl/glyph_serializer.sv
// Renders one character code at a time into a column-major pixel stream for
// an LED column driver, reading the bitmap from an external combinational ROM.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : char handshake in, pixel handshake out (slave side)
//   rom_addr   : registered character code, straight to the font ROM
//   rom_data   : 35-bit glyph, bit 34 = row0/col0, bit 34-(row*5+col)
// Flow: IDLE accepts a code, FETCH latches the ROM word for one cycle, EMIT
// streams 7*(5+SPACING) pixels. The last pixel's acceptance can take the next
// code directly, so back-to-back glyphs cost a single FETCH bubble.
module glyph_serializer
  import glyph_pkg::*;
#(
  parameter int SPACING    = 1,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  glyph_serializer_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [GLYPH_BITS-1:0] rom_data
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] code_q;
  logic [GLYPH_BITS-1:0] glyph_q;
  logic                  load_code;
  logic                  load_glyph;
  logic                  advance;
  logic                  ready;
  logic                  emit;
  logic [2:0]            col, row;
  logic                  pos_col_last, pos_glyph_last;
  logic [GLYPH_BITS-1:0] glyph_sh;
  logic                  lit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      glyph_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_code)  code_q  <= bus.char_code;
      if (load_glyph) glyph_q <= rom_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    load_code  = 1'b0;
    load_glyph = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.char_valid) begin
          load_code = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        load_glyph = 1'b1;
        state_d    = EMIT;
      end
      EMIT: begin
        advance = bus.pix_ready;
        // Final pixel leaving: open the char port in the same cycle.
        if (bus.pix_ready && pos_glyph_last) begin
          ready = 1'b1;
          if (bus.char_valid) begin
            load_code = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign emit = (state_q == EMIT);

  // Position is held at 0/0 outside EMIT so every glyph starts at the top-left.
  glyph_pos_counter #(.SPACING(SPACING)) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (advance),
    .clear      (!emit),
    .col        (col),
    .row        (row),
    .col_last   (pos_col_last),
    .glyph_last (pos_glyph_last)
  );

  // Shift the wanted bit up to the MSB; avoids an out-of-range bit select
  // when the position sits in a spacing column.
  assign glyph_sh = glyph_q << pix_index(row, col);
  assign lit      = (col < 3'(GLYPH_COLS)) && glyph_sh[GLYPH_BITS-1];

  // Outputs are forced low while reset is held, before the state has settled.
  assign bus.char_ready = rst_n && ready;
  assign bus.pix_valid  = rst_n && emit;
  assign bus.pix_on     = rst_n && emit && lit;
  assign bus.col_last   = rst_n && emit && pos_col_last;
  assign bus.glyph_last = rst_n && emit && pos_glyph_last;

  assign rom_addr = code_q;

endmodule
